// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ producers.
// Loads the winner's byte, waits for the frame, then acks or reports a timeout.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        ack,
  output logic                    err,
  output logic                    tx_load,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_busy,
  output logic                    ctl_busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0] LAST = PW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [CW-1:0]   cnt;
  logic            found;
  logic [PW-1:0]   win;
  logic [PW-1:0]   nxt_ptr;
  logic            hold;

  // First pending requester at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      int j;
      j = (int'(rr_ptr) + i) % N_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = PW'(j);
      end
    end
  end

  assign nxt_ptr = (owner == LAST) ? '0 : owner + 1'b1;

  // The ack/err cycle itself never arbitrates.
  assign hold = (|ack) | err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      cnt      <= '0;
      grant    <= '0;
      ack      <= '0;
      err      <= 1'b0;
      tx_load  <= 1'b0;
      tx_data  <= '0;
      ctl_busy <= 1'b0;
    end else begin
      tx_load <= 1'b0;
      ack     <= '0;
      err     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found && !hold) begin
            state    <= LOAD;
            owner    <= win;
            grant    <= ONE << win;
            tx_data  <= req_data[win*DATA_W +: DATA_W];
            tx_load  <= 1'b1;
            ctl_busy <= 1'b1;
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == CNT_MAX) begin
            err      <= 1'b1;
            grant    <= '0;
            rr_ptr   <= nxt_ptr;
            ctl_busy <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            ack      <= grant;
            grant    <= '0;
            rr_ptr   <= nxt_ptr;
            ctl_busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple UART busy model.
// Monitor checks every load and every ack/err against queued expectations.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int TO = 16;
  localparam int BUSY_CYC = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   grant;
  logic [N-1:0]   ack;
  logic           err;
  logic           tx_load;
  logic [W-1:0]   tx_data;
  logic           tx_busy;
  logic           ctl_busy;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .grant(grant), .ack(ack), .err(err), .tx_load(tx_load),
    .tx_data(tx_data), .tx_busy(tx_busy), .ctl_busy(ctl_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [W-1:0] data;
    bit         is_err;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit busy_en = 1'b1;
  bit gap_chk = 1'b0;
  int last_end = -1;
  int load_cyc = 0;
  logic [W-1:0] cur_data = '0;
  bit in_frame = 1'b0;
  logic [N-1:0] prev_ack = '0;
  logic prev_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N-1:0] oh(int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic bad(string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  task automatic push(int idx, logic [W-1:0] d, bit e);
    exp_t x;
    x.idx = idx;
    x.data = d;
    x.is_err = e;
    sbq.push_back(x);
  endtask

  task automatic wait_end();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ack != '0 || err) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bad("wait_end timed out");
  endtask

  task automatic wait_load();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_load) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bad("wait_load timed out");
  endtask

  // UART model: busy rises the cycle after the load strobe.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_load && busy_en) begin
        @(negedge clk);
        tx_busy = 1'b1;
        repeat (BUSY_CYC) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 1'b0;
        prev_ack = '0;
        prev_err = 1'b0;
        continue;
      end
      if (prev_ack != '0 || prev_err) begin
        chk("ack_pulse_width", 32'(ack), 0);
        chk("err_pulse_width", 32'(err), 0);
      end
      if (tx_load) begin
        if (sbq.size() == 0) begin
          bad("unexpected tx_load");
        end else begin
          chk("grant", 32'(grant), 32'(oh(sbq[0].idx)));
          chk("tx_data", 32'(tx_data), 32'(sbq[0].data));
          cur_data = sbq[0].data;
          load_cyc = cyc;
          in_frame = 1'b1;
          if (gap_chk && last_end >= 0)
            chk("idle_gap", 32'(cyc - last_end), 2);
        end
      end else if (in_frame && grant != '0) begin
        chk("tx_data_hold", 32'(tx_data), 32'(cur_data));
        chk("ctl_busy_frame", 32'(ctl_busy), 1);
      end
      if (ack != '0 || err) begin
        if (sbq.size() == 0) begin
          bad("unexpected ack/err");
        end else begin
          e = sbq.pop_front();
          chk("ack", 32'(ack), e.is_err ? 32'd0 : 32'(oh(e.idx)));
          chk("err", 32'(err), 32'(e.is_err));
          chk("grant_released", 32'(grant), 0);
          if (e.is_err)
            chk("timeout_cycles", 32'(cyc - load_cyc), TO + 1);
          last_end = cyc;
          in_frame = 1'b0;
        end
      end
      prev_ack = ack;
      prev_err = err;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req = '0;
    req_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_tx_load", 32'(tx_load), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_ctl_busy", 32'(ctl_busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // Contention from rr_ptr=0: 0,1,2,3,0
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'hA0 + 8'(i);
    gap_chk = 1'b1;
    last_end = -1;
    push(0, 8'hA0, 0);
    push(1, 8'hA1, 0);
    push(2, 8'hA2, 0);
    push(3, 8'hA3, 0);
    push(0, 8'hA0, 0);
    req = 4'b1111;
    repeat (5) wait_end();
    req = '0;
    gap_chk = 1'b0;
    repeat (3) @(negedge clk);

    // Single requester 1
    req_data[15:8] = 8'h5B;
    push(1, 8'h5B, 0);
    req = 4'b0010;
    wait_end();
    req = '0;
    repeat (3) @(negedge clk);

    // Serve 2 so rr_ptr=3, then 3 wins over 0, then 0
    req_data[23:16] = 8'hC2;
    push(2, 8'hC2, 0);
    req = 4'b0100;
    wait_end();
    req_data[31:24] = 8'hD3;
    req_data[7:0] = 8'hD0;
    push(3, 8'hD3, 0);
    push(0, 8'hD0, 0);
    req = 4'b1001;
    wait_end();
    req = 4'b0001;
    wait_end();
    req = '0;
    repeat (3) @(negedge clk);

    // Timeout on requester 2, then 3 must win over 2
    busy_en = 1'b0;
    req_data[23:16] = 8'hE2;
    push(2, 8'hE2, 1);
    req = 4'b0100;
    wait_end();
    req = '0;
    busy_en = 1'b1;
    repeat (3) @(negedge clk);
    req_data[31:24] = 8'hF3;
    push(3, 8'hF3, 0);
    push(2, 8'hE2, 0);
    req = 4'b1100;
    wait_end();
    req = 4'b0100;
    wait_end();
    req = '0;
    repeat (3) @(negedge clk);

    // Drop req and change data after grant
    req_data[7:0] = 8'h3C;
    push(0, 8'h3C, 0);
    req = 4'b0001;
    wait_load();
    req = '0;
    req_data[7:0] = 8'hFF;
    wait_end();
    repeat (3) @(negedge clk);

    // Reset in WAIT_DONE kills the frame silently
    req_data[15:8] = 8'h77;
    push(1, 8'h77, 0);
    req = 4'b0010;
    wait_load();
    repeat (4) @(negedge clk);
    chk("mid_ctl_busy", 32'(ctl_busy), 1);
    chk("mid_tx_busy", 32'(tx_busy), 1);
    rst = 1'b1;
    req = '0;
    sbq.delete();
    @(negedge clk);
    chk("mrst_grant", 32'(grant), 0);
    chk("mrst_tx_load", 32'(tx_load), 0);
    chk("mrst_tx_data", 32'(tx_data), 0);
    chk("mrst_ctl_busy", 32'(ctl_busy), 0);
    chk("mrst_ack", 32'(ack), 0);
    rst = 1'b0;
    repeat (15) @(negedge clk);

    // rr_ptr back at 0: requester 0 beats 1
    req_data[7:0] = 8'h11;
    push(0, 8'h11, 0);
    req = 4'b0011;
    wait_end();
    req = '0;
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
